// File: rtl/collision_pkg.sv
// Shared defaults, FSM state type and derived constants for the collision engine.
// Helper functions let the top recompute thresholds when parameters are overridden.
package collision_pkg;

  localparam int DEF_N_PINS        = 10;
  localparam int DEF_XW            = 11;
  localparam int DEF_YW            = 10;
  localparam int DEF_VW            = 16;
  localparam int DEF_BALL_MASS     = 2;
  localparam int DEF_PIN_MASS      = 1;
  localparam int DEF_BALL_RADIUS   = 39;
  localparam int DEF_PIN_RADIUS    = 21;
  localparam int DEF_SCREEN_WIDTH  = 1024;
  localparam int DEF_SCREEN_HEIGHT = 768;
  localparam bit DEF_PIN_PIN_EN    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BALL = 2'd1,
    ST_PAIR = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int pair_count(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int dist_width(input int xw, input int yw);
    return 2 * ((xw > yw) ? xw : yw) + 1;
  endfunction

  function automatic int contact_thresh(input int ra, input int rb);
    return (ra + rb) * (ra + rb);
  endfunction

  localparam int PAIR_CNT        = pair_count(DEF_N_PINS);
  localparam int DIST_W          = dist_width(DEF_XW, DEF_YW);
  localparam int BALL_PIN_THRESH = contact_thresh(DEF_BALL_RADIUS, DEF_PIN_RADIUS);
  localparam int PIN_PIN_THRESH  = contact_thresh(DEF_PIN_RADIUS, DEF_PIN_RADIUS);

endpackage

// File: rtl/dist_sq_cmp.sv
// Combinational squared-distance contact test: |dx|^2 + |dy|^2 <= threshold.
// Differences are taken without wrap so unsigned coordinates never alias.
module dist_sq_cmp #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int DW = 23
) (
  input  logic [XW-1:0] a_x_in,
  input  logic [YW-1:0] a_y_in,
  input  logic [XW-1:0] b_x_in,
  input  logic [YW-1:0] b_y_in,
  input  logic [DW-1:0] thresh_in,
  output logic          contact_out
);

  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic [DW-1:0] w_d2;

  assign w_dx = (a_x_in >= b_x_in) ? (a_x_in - b_x_in) : (b_x_in - a_x_in);
  assign w_dy = (a_y_in >= b_y_in) ? (a_y_in - b_y_in) : (b_y_in - a_y_in);
  assign w_d2 = (DW'(w_dx) * DW'(w_dx)) + (DW'(w_dy) * DW'(w_dy));

  assign contact_out = (w_d2 <= thresh_in);

endmodule

// File: rtl/collision_engine.sv
// Sequential ball-pin then pin-pin collision resolver sharing one distance comparator.
// state | meaning: IDLE wait for start | BALL pin k vs ball | PAIR pin i vs pin j | DONE publish results
module collision_engine
  import collision_pkg::*;
#(
  parameter int N_PINS        = DEF_N_PINS,
  parameter int XW            = DEF_XW,
  parameter int YW            = DEF_YW,
  parameter int VW            = DEF_VW,
  parameter int BALL_MASS     = DEF_BALL_MASS,
  parameter int PIN_MASS      = DEF_PIN_MASS,
  parameter int BALL_RADIUS   = DEF_BALL_RADIUS,
  parameter int PIN_RADIUS    = DEF_PIN_RADIUS,
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter bit PIN_PIN_EN    = DEF_PIN_PIN_EN
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic [XW-1:0]                 ball_x_in,
  input  logic [YW-1:0]                 ball_y_in,
  input  logic signed [VW-1:0]          ball_vx_in,
  input  logic signed [VW-1:0]          ball_vy_in,
  input  logic [N_PINS-1:0][XW-1:0]     pins_x_in,
  input  logic [N_PINS-1:0][YW-1:0]     pins_y_in,
  input  logic [N_PINS-1:0][VW-1:0]     pins_vx_in,
  input  logic [N_PINS-1:0][VW-1:0]     pins_vy_in,
  input  logic [N_PINS-1:0]             pins_active_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [N_PINS-1:0][VW-1:0]     pins_vx_out,
  output logic [N_PINS-1:0][VW-1:0]     pins_vy_out,
  output logic [N_PINS-1:0]             pins_hit_out
);

  localparam int IW = $clog2(N_PINS);
  localparam int DW = dist_width(XW, YW);
  localparam int MW = VW + 16;
  localparam logic [DW-1:0] THR_BP = DW'(contact_thresh(BALL_RADIUS, PIN_RADIUS));
  localparam logic [DW-1:0] THR_PP = DW'(contact_thresh(PIN_RADIUS, PIN_RADIUS));
  localparam logic [IW-1:0] LAST_K = IW'(N_PINS - 1);
  localparam logic [IW-1:0] LAST_I = IW'(N_PINS - 2);
  localparam logic signed [MW-1:0] C_BALL = MW'(2 * BALL_MASS);
  localparam logic signed [MW-1:0] C_PIN  = MW'(BALL_MASS - PIN_MASS);
  localparam logic signed [MW-1:0] C_DEN  = MW'(BALL_MASS + PIN_MASS);
  localparam logic signed [MW-1:0] V_MAX  = MW'(2 ** (VW - 1) - 1);
  localparam logic signed [MW-1:0] V_MIN  = MW'(-(2 ** (VW - 1)));

  state_t                      r_state;
  logic [IW-1:0]               r_k, r_i, r_j;
  logic                        r_busy, r_done;
  logic [XW-1:0]               r_bx;
  logic [YW-1:0]               r_by;
  logic signed [VW-1:0]        r_bvx, r_bvy;
  logic [N_PINS-1:0][XW-1:0]   r_px;
  logic [N_PINS-1:0][YW-1:0]   r_py;
  logic [N_PINS-1:0][VW-1:0]   r_pvx, r_pvy;
  logic [N_PINS-1:0]           r_act, r_hit;
  logic [N_PINS-1:0][VW-1:0]   r_out_vx, r_out_vy;
  logic [N_PINS-1:0]           r_out_hit;

  logic [N_PINS-1:0]           w_elig;
  logic [XW-1:0]               w_ax, w_bx;
  logic [YW-1:0]               w_ay, w_by;
  logic [DW-1:0]               w_thr;
  logic                        w_ok, w_contact, w_hit;
  logic signed [MW-1:0]        w_num_x, w_num_y;
  logic [VW-1:0]               w_new_vx, w_new_vy;

  function automatic logic [VW-1:0] sat_v(input logic signed [MW-1:0] v);
    if (v > V_MAX) return VW'(V_MAX);
    if (v < V_MIN) return VW'(V_MIN);
    return VW'(v);
  endfunction

  always_comb begin
    for (int k = 0; k < N_PINS; k++) begin
      w_elig[k] = r_act[k] && (int'(r_px[k]) < SCREEN_WIDTH) && (int'(r_py[k]) < SCREEN_HEIGHT);
    end
  end

  // BALL compares ball vs pin k; PAIR reuses the same comparator for pin i vs pin j.
  always_comb begin
    w_ax  = r_bx;
    w_ay  = r_by;
    w_bx  = r_px[r_k];
    w_by  = r_py[r_k];
    w_thr = THR_BP;
    w_ok  = w_elig[r_k];
    if (r_state == ST_PAIR) begin
      w_ax  = r_px[r_i];
      w_ay  = r_py[r_i];
      w_bx  = r_px[r_j];
      w_by  = r_py[r_j];
      w_thr = THR_PP;
      w_ok  = w_elig[r_i] && w_elig[r_j];
    end
  end

  dist_sq_cmp #(.XW(XW), .YW(YW), .DW(DW)) u_dist (
    .a_x_in      (w_ax),
    .a_y_in      (w_ay),
    .b_x_in      (w_bx),
    .b_y_in      (w_by),
    .thresh_in   (w_thr),
    .contact_out (w_contact)
  );

  assign w_hit = w_contact && w_ok;

  // Signed division truncates toward zero before saturation.
  assign w_num_x  = (C_BALL * MW'(r_bvx)) - (C_PIN * MW'($signed(r_pvx[r_k])));
  assign w_num_y  = (C_BALL * MW'(r_bvy)) - (C_PIN * MW'($signed(r_pvy[r_k])));
  assign w_new_vx = sat_v(w_num_x / C_DEN);
  assign w_new_vy = sat_v(w_num_y / C_DEN);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bx      <= '0;
      r_by      <= '0;
      r_bvx     <= '0;
      r_bvy     <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_pvx     <= '0;
      r_pvy     <= '0;
      r_act     <= '0;
      r_hit     <= '0;
      r_out_vx  <= '0;
      r_out_vy  <= '0;
      r_out_hit <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_bx    <= ball_x_in;
            r_by    <= ball_y_in;
            r_bvx   <= ball_vx_in;
            r_bvy   <= ball_vy_in;
            r_px    <= pins_x_in;
            r_py    <= pins_y_in;
            r_pvx   <= pins_vx_in;
            r_pvy   <= pins_vy_in;
            r_act   <= pins_active_in;
            r_hit   <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= IW'(1);
            r_busy  <= 1'b1;
            r_state <= ST_BALL;
          end
        end
        ST_BALL: begin
          if (w_hit) begin
            r_pvx[r_k] <= w_new_vx;
            r_pvy[r_k] <= w_new_vy;
            r_hit[r_k] <= 1'b1;
          end
          if (r_k == LAST_K) begin
            r_k     <= '0;
            r_state <= PIN_PIN_EN ? ST_PAIR : ST_DONE;
          end else begin
            r_k <= r_k + IW'(1);
          end
        end
        ST_PAIR: begin
          if (w_hit) begin
            r_pvx[r_i] <= r_pvx[r_j];
            r_pvx[r_j] <= r_pvx[r_i];
            r_pvy[r_i] <= r_pvy[r_j];
            r_pvy[r_j] <= r_pvy[r_i];
            r_hit[r_i] <= 1'b1;
            r_hit[r_j] <= 1'b1;
          end
          if (r_j == LAST_K) begin
            if (r_i == LAST_I) begin
              r_i     <= '0;
              r_j     <= '0;
              r_state <= ST_DONE;
            end else begin
              r_i <= r_i + IW'(1);
              r_j <= r_i + IW'(2);
            end
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        ST_DONE: begin
          r_out_vx  <= r_pvx;
          r_out_vy  <= r_pvy;
          r_out_hit <= r_hit;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_out     = r_busy;
  assign done_out     = r_done;
  assign pins_vx_out  = r_out_vx;
  assign pins_vy_out  = r_out_vy;
  assign pins_hit_out = r_out_hit;

endmodule

// File: tb/tb_collision_engine.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops them on every done_out.
module tb_collision_engine;
  import collision_pkg::*;

  localparam int N  = DEF_N_PINS;
  localparam int XW = DEF_XW;
  localparam int YW = DEF_YW;
  localparam int VW = DEF_VW;
  localparam int CW = N * VW;
  localparam int LAT = 56;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic start_in = 1'b0;
  logic [XW-1:0] ball_x_in;
  logic [YW-1:0] ball_y_in;
  logic signed [VW-1:0] ball_vx_in, ball_vy_in;
  logic [N-1:0][XW-1:0] pins_x_in;
  logic [N-1:0][YW-1:0] pins_y_in;
  logic [N-1:0][VW-1:0] pins_vx_in, pins_vy_in;
  logic [N-1:0] pins_active_in;
  logic busy_out, done_out;
  logic [N-1:0][VW-1:0] pins_vx_out, pins_vy_out;
  logic [N-1:0] pins_hit_out;

  collision_engine dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .ball_x_in(ball_x_in), .ball_y_in(ball_y_in),
    .ball_vx_in(ball_vx_in), .ball_vy_in(ball_vy_in),
    .pins_x_in(pins_x_in), .pins_y_in(pins_y_in),
    .pins_vx_in(pins_vx_in), .pins_vy_in(pins_vy_in),
    .pins_active_in(pins_active_in),
    .busy_out(busy_out), .done_out(done_out),
    .pins_vx_out(pins_vx_out), .pins_vy_out(pins_vy_out),
    .pins_hit_out(pins_hit_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0][VW-1:0] vx;
    logic [N-1:0][VW-1:0] vy;
    logic [N-1:0]         hit;
    int                   acc;
    int                   id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails  = 0;
  int n_done = 0;

  int m_bx, m_by, m_bvx, m_bvy;
  int m_px[N], m_py[N], m_pvx[N], m_pvy[N];
  bit m_act[N];

  task automatic chk(input string nm, input int id, input logic [CW-1:0] a, input logic [CW-1:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s run=%0d actual=%h expected=%h", nm, id, a, e);
    end
  endtask

  function automatic int sat_v(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic bit touching(input int ax, input int ay, input int bx, input int by, input int r);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx * dx + dy * dy) <= r * r;
  endfunction

  function automatic bit eligible(input int k);
    return m_act[k] && (m_px[k] < DEF_SCREEN_WIDTH) && (m_py[k] < DEF_SCREEN_HEIGHT);
  endfunction

  // Reference: every pin against the ball, then every pair in order, on plain integers.
  function automatic void build_exp(output exp_t e);
    int vx[N], vy[N], t;
    bit hit[N];
    longint bm, pm;
    bm = DEF_BALL_MASS;
    pm = DEF_PIN_MASS;
    for (int k = 0; k < N; k++) begin
      vx[k] = m_pvx[k]; vy[k] = m_pvy[k]; hit[k] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (eligible(k) && touching(m_bx, m_by, m_px[k], m_py[k], DEF_BALL_RADIUS + DEF_PIN_RADIUS)) begin
        vx[k] = sat_v((2 * bm * m_bvx - (bm - pm) * vx[k]) / (bm + pm));
        vy[k] = sat_v((2 * bm * m_bvy - (bm - pm) * vy[k]) / (bm + pm));
        hit[k] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (eligible(i) && eligible(j) && touching(m_px[i], m_py[i], m_px[j], m_py[j], 2 * DEF_PIN_RADIUS)) begin
          t = vx[i]; vx[i] = vx[j]; vx[j] = t;
          t = vy[i]; vy[i] = vy[j]; vy[j] = t;
          hit[i] = 1'b1; hit[j] = 1'b1;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      e.vx[k] = VW'(vx[k]); e.vy[k] = VW'(vy[k]); e.hit[k] = hit[k];
    end
    e.acc = 0;
    e.id  = 0;
  endfunction

  task automatic apply_inputs();
    ball_x_in  = XW'(m_bx);
    ball_y_in  = YW'(m_by);
    ball_vx_in = VW'(m_bvx);
    ball_vy_in = VW'(m_bvy);
    for (int k = 0; k < N; k++) begin
      pins_x_in[k]      = XW'(m_px[k]);
      pins_y_in[k]      = YW'(m_py[k]);
      pins_vx_in[k]     = VW'(m_pvx[k]);
      pins_vy_in[k]     = VW'(m_pvy[k]);
      pins_active_in[k] = m_act[k];
    end
  endtask

  task automatic scramble_ports();
    ball_x_in  = XW'($urandom);
    ball_y_in  = YW'($urandom);
    ball_vx_in = VW'($urandom);
    ball_vy_in = VW'($urandom);
    for (int k = 0; k < N; k++) begin
      pins_x_in[k]  = XW'($urandom_range(0, 600));
      pins_y_in[k]  = YW'($urandom_range(0, 600));
      pins_vx_in[k] = VW'($urandom);
      pins_vy_in[k] = VW'($urandom);
    end
    pins_active_in = N'($urandom);
  endtask

  task automatic clear_pins();
    m_bx = 900; m_by = 700; m_bvx = 0; m_bvy = 0;
    for (int k = 0; k < N; k++) begin
      m_px[k] = 0; m_py[k] = 0; m_pvx[k] = 0; m_pvy[k] = 0; m_act[k] = 1'b0;
    end
  endtask

  function automatic int rnd_v();
    logic signed [15:0] t;
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: begin
        t = 16'($urandom);
        return int'(t);
      end
    endcase
  endfunction

  task automatic wait_done(input int id, input int n0);
    for (int t = 0; t < 150; t++) begin
      @(negedge clk_in); #1;
      if (n_done != n0) break;
    end
    chk("done_seen", id, CW'(n_done != n0), CW'(1));
  endtask

  task automatic accept(input int id, input bit push, output int acc);
    exp_t e;
    @(negedge clk_in);
    apply_inputs();
    build_exp(e);
    e.id = id;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    acc = cyc;
    e.acc = acc;
    if (push) exp_q.push_back(e);
    chk("busy_after_accept", id, CW'(busy_out), CW'(1));
    scramble_ports();
  endtask

  task automatic run_case(input int id);
    int acc, n0;
    n0 = n_done;
    accept(id, 1'b1, acc);
    wait_done(id, n0);
  endtask

  task automatic setup_basic();
    clear_pins();
    m_bx = 100; m_by = 100; m_bvx = 0; m_bvy = -30;
    m_act[0] = 1'b1; m_px[0] = 100; m_py[0] = 150;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (done_out) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", -1, CW'(1), CW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pins_vx", e.id, CW'(pins_vx_out), CW'(e.vx));
          chk("pins_vy", e.id, CW'(pins_vy_out), CW'(e.vy));
          chk("pins_hit", e.id, CW'(pins_hit_out), CW'(e.hit));
          chk("latency", e.id, CW'(cyc - e.acc), CW'(LAT));
        end
      end
    end
  end

  initial begin : stim
    int acc, n0;
    clear_pins();
    apply_inputs();
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("reset_busy", 0, CW'(busy_out), CW'(0));
    chk("reset_done", 0, CW'(done_out), CW'(0));
    chk("reset_vx", 0, CW'(pins_vx_out), CW'(0));
    chk("reset_vy", 0, CW'(pins_vy_out), CW'(0));
    chk("reset_hit", 0, CW'(pins_hit_out), CW'(0));

    setup_basic(); run_case(1);
    setup_basic(); m_py[0] = 160; m_pvx[0] = 3; m_pvy[0] = 7; run_case(2);
    setup_basic(); m_py[0] = 161; m_pvx[0] = 3; m_pvy[0] = 7; run_case(3);

    clear_pins();
    m_act[1] = 1'b1; m_px[1] = 300; m_py[1] = 200; m_pvx[1] = 5;
    m_act[2] = 1'b1; m_px[2] = 342; m_py[2] = 200; m_pvx[2] = -7;
    run_case(4);
    m_px[2] = 343; run_case(5);

    setup_basic(); m_bvx = -32768; run_case(6);
    setup_basic(); m_bvx = -32768; m_act[0] = 1'b0; run_case(7);
    clear_pins(); m_bx = 1000; m_by = 100; m_bvx = -32768;
    m_act[0] = 1'b1; m_px[0] = 1024; m_py[0] = 100; m_pvx[0] = 9; run_case(8);

    for (int r = 0; r < 24; r++) begin
      m_bx = $urandom_range(250, 450); m_by = $urandom_range(250, 450);
      m_bvx = rnd_v(); m_bvy = rnd_v();
      for (int k = 0; k < N; k++) begin
        m_px[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 1100) : $urandom_range(250, 450);
        m_py[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(740, 800) : $urandom_range(250, 450);
        m_pvx[k] = rnd_v(); m_pvy[k] = rnd_v();
        m_act[k] = ($urandom_range(0, 3) != 0);
      end
      run_case(100 + r);
    end

    // Extra start pulses mid-run and on the DONE edge must not launch a second run.
    setup_basic();
    n0 = n_done;
    accept(200, 1'b1, acc);
    repeat (4) @(posedge clk_in); #1;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (50) @(posedge clk_in); #1;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (70) @(negedge clk_in);
    chk("single_run_count", 200, CW'(n_done - n0), CW'(1));
    chk("idle_after_run", 200, CW'(busy_out), CW'(0));

    setup_basic();
    n0 = n_done;
    accept(300, 1'b0, acc);
    repeat (19) @(posedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    chk("abort_busy", 300, CW'(busy_out), CW'(0));
    chk("abort_done", 300, CW'(done_out), CW'(0));
    chk("abort_vx", 300, CW'(pins_vx_out), CW'(0));
    chk("abort_vy", 300, CW'(pins_vy_out), CW'(0));
    chk("abort_hit", 300, CW'(pins_hit_out), CW'(0));
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (70) @(negedge clk_in);
    chk("no_done_after_abort", 300, CW'(n_done - n0), CW'(0));

    setup_basic(); m_pvx[0] = -11; run_case(301);

    repeat (5) @(negedge clk_in);
    chk("queue_drained", 999, CW'(exp_q.size()), CW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/collision_engine.md
COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 The block SHALL take these parameters: N_PINS 10 (pin count, 2..16); XW 11 (x width); YW 10 (y width); VW 16 (signed velocity width); BALL_MASS 2; PIN_MASS 1; BALL_RADIUS 39; PIN_RADIUS 21; SCREEN_WIDTH 1024; SCREEN_HEIGHT 768; PIN_PIN_EN 1 (enables the pin-pin phase).
REQ-002 clk_in  input  1  the single clock; all state is on its rising edge.
REQ-003 rst_n_in  input  1  asynchronous, active-low reset.
REQ-004 start_in  input  1  request to run; accepted only when busy_out=0.
REQ-005 ball_x_in / ball_y_in  input  XW / YW  ball position, unsigned.
REQ-006 ball_vx_in / ball_vy_in  input  VW  ball velocity, signed.
REQ-007 pins_x_in / pins_y_in  input  N_PINS x XW / N_PINS x YW  pin positions, unsigned.
REQ-008 pins_vx_in / pins_vy_in  input  N_PINS x VW  pin velocities, signed.
REQ-009 pins_active_in  input  N_PINS  per-pin enable; a 0 pin is excluded from every check.
REQ-010 busy_out  output  1  high from the acceptance cycle until done_out.
REQ-011 done_out  output  1  one-cycle pulse when results are valid.
REQ-012 pins_vx_out / pins_vy_out  output  N_PINS x VW  resulting pin velocities, signed.
REQ-013 pins_hit_out  output  N_PINS  pins touched during the last run.

Function
REQ-014 On acceptance (start_in=1, IDLE), the block SHALL snapshot all inputs into working registers, clear the working hit flags, and enter BALL with index 0.
- start_in is ignored while busy_out=1.
REQ-015 The FSM states SHALL be IDLE, BALL, PAIR and DONE.
- BALL checks pin k in cycle k, for N_PINS cycles.
- PAIR checks one pair (i,j), i<j, per cycle in lexicographic order, for N_PINS*(N_PINS-1)/2 cycles.
- If PIN_PIN_EN=0, PAIR is skipped.
- DONE lasts one cycle, then the FSM returns to IDLE.
REQ-016 done_out SHALL pulse exactly N_PINS + N_PINS*(N_PINS-1)/2 + 1 cycles after the acceptance edge.
- This is 56 cycles at the defaults.
- With PIN_PIN_EN=0 it is N_PINS+1.
REQ-017 Distance rule:
- dx = |a_x - b_x| and dy = |a_y - b_y|, computed without wrap.
- d2 = dx*dx + dy*dy, at full width 2*max(XW,YW)+1.
- Contact when d2 <= (Ra+Rb)^2; equality counts as contact.
REQ-018 A pin is eligible only if active=1, x < SCREEN_WIDTH and y < SCREEN_HEIGHT.
- A pair is checked only if both pins are eligible.
REQ-019 On ball-pin contact for an eligible pin, the block SHALL set the pin's working velocity per axis and set its hit flag:
- v' = (2*BALL_MASS*v_ball - (BALL_MASS-PIN_MASS)*v_pin) / (BALL_MASS+PIN_MASS).
- Signed, full-precision intermediate, truncation toward zero.
- Result saturated to VW bits.
REQ-020 On pin-pin contact, the block SHALL swap both axes of the two pins' current working velocities and set both hit flags.
- Current working velocities include earlier BALL and PAIR updates in the same run.
REQ-021 Output registers SHALL load from the working registers only in DONE.
- They hold between runs; inputs changing mid-run have no effect.

Reset
REQ-022 While rst_n_in=0, the block SHALL immediately force:
- FSM to IDLE, all indices to 0;
- busy_out=0, done_out=0;
- pins_vx_out, pins_vy_out and pins_hit_out to 0;
- working registers to 0.
REQ-023 Reset asserted mid-run SHALL abort the run with no done_out; a later start begins a fresh run.

Structure
REQ-024 The defaults, the FSM state enum, and the localparams (pair count, distance width, contact thresholds) SHALL reside in the shared package collision_pkg.
REQ-025 The absolute-difference, squaring and threshold compare SHALL be one sub-module, dist_sq_cmp.
- It is instantiated once and shared by BALL and PAIR.
- It is purely combinational.

Verification (defaults unless stated)
REQ-026 Ball (100,100), v=(0,-30); pin0 (100,150), v 0; all other pins inactive -> done_out at cycle 56; pins_vy_out[0]=-40, pins_vx_out[0]=0, pins_hit_out=10'h001.
REQ-027 Boundary: pin0 at ball_y+60 -> hit; pin0 at ball_y+61 -> no hit, velocity passes through unchanged.
REQ-028 Pins 1 (300,200) vx=5 and 2 (342,200) vx=-7; ball far away -> pins_vx_out[1]=-7, pins_vx_out[2]=5, pins_hit_out=10'h006; pins at distance 43 -> no swap.
REQ-029 ball_vx_in=-32768, pin vx 0, contact -> pins_vx_out=-32768 (saturated); pins_active_in=0 or x=1024 on the same pin -> no hit.
REQ-030 start_in pulsed at cycles 0, 5 and 56 -> exactly one run, done at cycle 56; rst_n_in low at cycle 20 -> busy_out=0 at once, no done_out, outputs 0.
